// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the microprogrammed RV32I core.
// Holds the PC and runs a single-outstanding-request fetch handshake.
// Latches the fetched word into the instruction register.
// Reports misaligned fetch addresses and memory timeouts as faults.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic        pc_src,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instruction,
  output logic [31:0] ir_pc,
  output logic [31:0] pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  CODE_NONE     = 2'b00;
  localparam logic [1:0]  CODE_MISALIGN = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_value_reg, pc_value_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ir_pc_reg, ir_pc_next;
  logic        ir_valid_reg, ir_valid_next;
  logic [1:0]  fault_code_reg, fault_code_next;
  logic [15:0] cnt_reg, cnt_next;

  // PC update source and wait-cycle counter increment.
  logic [31:0] pc_target;
  logic [15:0] cnt_inc;
  logic        cnt_sat;

  assign pc_target = pc_src ? pc_next : (pc_value_reg + 32'd4);
  assign cnt_inc   = cnt_reg + 16'd1;
  assign cnt_sat   = (cnt_reg == 16'hFFFF);

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_value_reg   <= RESET_PC;
      mem_addr_reg   <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      ir_pc_reg      <= RESET_PC;
      ir_valid_reg   <= 1'b0;
      fault_code_reg <= CODE_NONE;
      cnt_reg        <= 16'd0;
    end else begin
      state_reg      <= state_next;
      pc_value_reg   <= pc_value_next;
      mem_addr_reg   <= mem_addr_next;
      instr_reg      <= instr_next;
      ir_pc_reg      <= ir_pc_next;
      ir_valid_reg   <= ir_valid_next;
      fault_code_reg <= fault_code_next;
      cnt_reg        <= cnt_next;
    end
  end

  // Next-state and datapath decisions for the fetch handshake.
  always_comb begin
    state_next      = state_reg;
    pc_value_next   = pc_value_reg;
    mem_addr_next   = mem_addr_reg;
    instr_next      = instr_reg;
    ir_pc_next      = ir_pc_reg;
    ir_valid_next   = ir_valid_reg;
    fault_code_next = fault_code_reg;
    cnt_next        = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (pc_write) begin
          // A PC write wins over a simultaneous fetch request.
          pc_value_next = pc_target;
          ir_valid_next = 1'b0;
        end else if (fetch_start) begin
          ir_valid_next = 1'b0;
          if (pc_value_reg[1:0] != 2'b00) begin
            state_next      = FAULT;
            fault_code_next = CODE_MISALIGN;
          end else begin
            state_next    = WAIT;
            mem_addr_next = pc_value_reg;
            cnt_next      = 16'd0;
          end
        end
      end

      WAIT: begin
        if (mem_ready) begin
          // Data arriving in the final allowed cycle is still accepted.
          state_next    = IDLE;
          instr_next    = mem_rdata;
          ir_pc_next    = mem_addr_reg;
          ir_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_sat ? cnt_reg : cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && !cnt_sat && (cnt_inc == TIMEOUT_LIMIT)) begin
            state_next      = FAULT;
            fault_code_next = CODE_TIMEOUT;
          end
        end
      end

      FAULT: begin
        // Only a PC write (trap vector load) leaves the fault state.
        if (pc_write) begin
          pc_value_next   = pc_target;
          fault_code_next = CODE_NONE;
          state_next      = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req     = (state_reg == WAIT);
  assign busy        = (state_reg == WAIT);
  assign fault       = (state_reg == FAULT);
  assign mem_addr    = mem_addr_reg;
  assign instruction = instr_reg;
  assign ir_pc       = ir_pc_reg;
  assign pc          = pc_value_reg;
  assign ir_valid    = ir_valid_reg;
  assign fault_code  = fault_code_reg;

endmodule
